cache_control: RTL and testbench

CACHE_CONTROL -- requirements
Module: cache_control

---
 rtl/cache_ctrl_pkg.sv | 26 ++
 rtl/sat_counter.sv | 24 ++
 rtl/cache_control.sv | 125 ++++++++++++
 tb/tb_cache_control.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_ctrl_pkg.sv
// Shared types for the cache controller: FSM states and the datapath mux-select encodings.
package cache_ctrl_pkg;

    localparam logic DATA_SEL_CPU_ENC  = 1'b0;
    localparam logic DATA_SEL_PMEM_ENC = 1'b1;
    localparam logic ADDR_SEL_CPU_ENC  = 1'b0;
    localparam logic ADDR_SEL_TAG_ENC  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_COMPARE   = 2'd1,
        ST_WRITEBACK = 2'd2,
        ST_FILL      = 2'd3
    } state_e;

    typedef enum logic {
        DSEL_CPU  = DATA_SEL_CPU_ENC,
        DSEL_PMEM = DATA_SEL_PMEM_ENC
    } data_sel_e;

    typedef enum logic {
        ASEL_CPU = ADDR_SEL_CPU_ENC,
        ASEL_TAG = ADDR_SEL_TAG_ENC
    } addr_sel_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;

    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/cache_control.sv
// Blocking write-back cache controller FSM with hit/miss performance counters.
module cache_control
    import cache_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             tag_hit,
    input  logic             line_valid,
    input  logic             line_dirty,
    input  logic             pmem_resp,
    output logic             mem_resp,
    output logic             pmem_read,
    output logic             pmem_write,
    output logic             load_data,
    output logic             load_tag,
    output logic             load_valid,
    output logic             load_dirty,
    output logic             valid_in,
    output logic             dirty_in,
    output logic             data_sel,
    output logic             addr_sel,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);

    state_e state_q, state_d;
    logic   req;
    logic   hit;
    logic   hit_inc;
    logic   miss_inc;

    assign req = mem_read | mem_write;
    assign hit = tag_hit & line_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs are decoded from the current state and inputs so a hit completes in the
    // COMPARE cycle itself; reset forcing IDLE therefore clears every strobe at once.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path infers a latch.
        state_d    = state_q;
        mem_resp   = 1'b0;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        load_data  = 1'b0;
        load_tag   = 1'b0;
        load_valid = 1'b0;
        load_dirty = 1'b0;
        valid_in   = 1'b0;
        dirty_in   = 1'b0;
        data_sel   = DSEL_CPU;
        addr_sel   = ASEL_CPU;
        hit_inc    = 1'b0;
        miss_inc   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req) state_d = ST_COMPARE;
            end
            ST_COMPARE: begin
                if (!req) begin
                    state_d = ST_IDLE;
                end else if (hit) begin
                    mem_resp = 1'b1;
                    hit_inc  = 1'b1;
                    state_d  = ST_IDLE;
                    if (mem_write) begin
                        load_data  = 1'b1;
                        data_sel   = DSEL_CPU;
                        load_dirty = 1'b1;
                        dirty_in   = 1'b1;
                    end
                end else begin
                    miss_inc = 1'b1;
                    state_d  = (line_valid && line_dirty) ? ST_WRITEBACK : ST_FILL;
                end
            end
            ST_WRITEBACK: begin
                pmem_write = 1'b1;
                addr_sel   = ASEL_TAG;
                if (pmem_resp) state_d = ST_FILL;
            end
            ST_FILL: begin
                pmem_read = 1'b1;
                addr_sel  = ASEL_CPU;
                if (pmem_resp) begin
                    load_data  = 1'b1;
                    data_sel   = DSEL_PMEM;
                    load_tag   = 1'b1;
                    load_valid = 1'b1;
                    valid_in   = 1'b1;
                    load_dirty = 1'b1;
                    dirty_in   = 1'b0;
                    state_d    = ST_COMPARE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (hit_inc),
        .count (hit_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (miss_inc),
        .count (miss_count)
    );

endmodule

// File: tb/tb_cache_control.sv
// Self-checking bench for cache_control: directed table, hand-written reset/idle sequences,
// and randomized transactions predicted from latency/count rules.
module tb_cache_control;

    localparam int CNT_W = 16;
    localparam int SAT_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic mem_read = 1'b0, mem_write = 1'b0;
    logic tag_hit = 1'b0, line_valid = 1'b0, line_dirty = 1'b0, pmem_resp = 1'b0;

    logic mem_resp, pmem_read, pmem_write, load_data, load_tag, load_valid, load_dirty;
    logic valid_in, dirty_in, data_sel, addr_sel;
    logic [CNT_W-1:0] hit_count, miss_count;

    logic s_mem_resp, s_pmem_read, s_pmem_write, s_load_data, s_load_tag, s_load_valid;
    logic s_load_dirty, s_valid_in, s_dirty_in, s_data_sel, s_addr_sel;
    logic [SAT_W-1:0] s_hit_count, s_miss_count;

    logic [10:0] outs;
    assign outs = {mem_resp, pmem_read, pmem_write, load_data, load_tag, load_valid,
                   load_dirty, valid_in, dirty_in, data_sel, addr_sel};

    always #5 clk = ~clk;

    cache_control #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .tag_hit(tag_hit), .line_valid(line_valid), .line_dirty(line_dirty),
        .pmem_resp(pmem_resp), .mem_resp(mem_resp), .pmem_read(pmem_read),
        .pmem_write(pmem_write), .load_data(load_data), .load_tag(load_tag),
        .load_valid(load_valid), .load_dirty(load_dirty), .valid_in(valid_in),
        .dirty_in(dirty_in), .data_sel(data_sel), .addr_sel(addr_sel),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    cache_control #(.CNT_W(SAT_W)) dut_s (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .tag_hit(tag_hit), .line_valid(line_valid), .line_dirty(line_dirty),
        .pmem_resp(pmem_resp), .mem_resp(s_mem_resp), .pmem_read(s_pmem_read),
        .pmem_write(s_pmem_write), .load_data(s_load_data), .load_tag(s_load_tag),
        .load_valid(s_load_valid), .load_dirty(s_load_dirty), .valid_in(s_valid_in),
        .dirty_in(s_dirty_in), .data_sel(s_data_sel), .addr_sel(s_addr_sel),
        .hit_count(s_hit_count), .miss_count(s_miss_count)
    );

    typedef struct {
        logic rd, wr, hit, valid, dirty;
        int   wb, wf, drop;
        int   exp_resp, exp_w, exp_r;
    } vec_t;

    typedef struct {
        int resp_c, wcnt, rcnt, fills, merges, bad;
    } obs_t;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_h   = 0;
    int exp_m   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint sat(input int v, input int w);
        longint top = (longint'(1) << w) - 1;
        return (v >= top) ? top : longint'(v);
    endfunction

    task automatic check_counters(input string tag);
        check({tag, ".hit_count"},    hit_count,    sat(exp_h, CNT_W));
        check({tag, ".miss_count"},   miss_count,   sat(exp_m, CNT_W));
        check({tag, ".s_hit_count"},  s_hit_count,  sat(exp_h, SAT_W));
        check({tag, ".s_miss_count"}, s_miss_count, sat(exp_m, SAT_W));
    endtask

    // Expected behaviour of one CPU transaction from the latency rules.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        bit miss = !(v.hit && v.valid);
        bit wbp  = miss && v.valid && v.dirty;
        r.exp_w    = wbp ? v.wb : 0;
        r.exp_r    = miss ? v.wf : 0;
        r.exp_resp = (v.drop >= 0) ? -1 : (miss ? 2 + r.exp_w + v.wf : 1);
        return r;
    endfunction

    // Drives one request, acting as main memory that answers on the wb-th / wf-th strobe cycle.
    task automatic run_txn(input vec_t v, output obs_t o);
        int limit;
        bit fill_seen;
        o.resp_c = -1; o.wcnt = 0; o.rcnt = 0; o.fills = 0; o.merges = 0; o.bad = 0;
        limit = 2 + v.wb + v.wf + 4;
        fill_seen = 1'b0;
        @(posedge clk); #1;
        mem_read = v.rd; mem_write = v.wr;
        tag_hit = v.hit; line_valid = v.valid; line_dirty = v.dirty; pmem_resp = 1'b0;
        for (int c = 0; c < limit; c++) begin
            @(negedge clk);
            if (pmem_write)     pmem_resp = (o.wcnt == v.wb - 1);
            else if (pmem_read) pmem_resp = (o.rcnt == v.wf - 1);
            else                pmem_resp = ($urandom_range(0, 3) == 0);
            #1;
            if (pmem_read && pmem_write) o.bad++;
            if (pmem_write) begin o.wcnt++; if (addr_sel !== 1'b1) o.bad++; end
            if (pmem_read)  begin o.rcnt++; if (addr_sel !== 1'b0) o.bad++; end
            if (load_tag) begin
                o.fills++;
                fill_seen = 1'b1;
                if ({load_data, data_sel, load_valid, valid_in, load_dirty, dirty_in,
                     pmem_resp, mem_resp} !== 8'b11111010) o.bad++;
            end else if (load_data) begin
                o.merges++;
                if ({data_sel, load_dirty, dirty_in, mem_resp, load_valid} !== 5'b01110) o.bad++;
            end else if (load_valid || load_dirty || valid_in || dirty_in || data_sel) begin
                o.bad++;
            end
            if (mem_resp) begin
                if (o.resp_c >= 0) o.bad++;
                if (mem_write && !load_data) o.bad++;
                o.resp_c = c;
            end
            @(posedge clk); #1;
            pmem_resp = 1'b0;
            if (fill_seen) {tag_hit, line_valid, line_dirty} = 3'b110;
            if (o.resp_c >= 0) break;
            if (c + 1 == v.drop) begin mem_read = 1'b0; mem_write = 1'b0; end
        end
        mem_read = 1'b0; mem_write = 1'b0;
    endtask

    task automatic apply(input string tag, input vec_t v);
        obs_t o;
        bit miss    = !(v.hit && v.valid);
        bit dropped = (v.drop >= 0);
        run_txn(v, o);
        if (miss) exp_m++;
        if (!dropped) exp_h++;
        check({tag, ".resp_cycle"}, o.resp_c, v.exp_resp);
        check({tag, ".wb_cycles"},  o.wcnt,   v.exp_w);
        check({tag, ".fill_cycles"}, o.rcnt,  v.exp_r);
        check({tag, ".fill_loads"}, o.fills,  miss ? 1 : 0);
        check({tag, ".merges"},     o.merges, (v.wr && !dropped) ? 1 : 0);
        check({tag, ".strobe_rules"}, o.bad,  0);
        check_counters(tag);
    endtask

    vec_t table_v[9];
    vec_t rv;

    initial begin
        table_v[0] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1, 1, -1,  1, 0, 0}; // read hit
        table_v[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1, 1, -1,  1, 0, 0}; // write hit
        table_v[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 5, -1,  7, 0, 5}; // clean miss, 5-cycle fill
        table_v[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1, 2, -1,  4, 0, 2}; // tag miss, clean line
        table_v[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3, 2, -1,  7, 3, 2}; // dirty miss
        table_v[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1, 1, -1,  4, 1, 1}; // rd+wr dirty miss
        table_v[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1, 1, -1,  1, 0, 0}; // rd+wr hit
        table_v[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2, 3, -1,  5, 0, 3}; // invalid dirty line: no writeback
        table_v[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2, 2,  2, -1, 2, 2}; // request dropped mid-writeback

        // Reset state
        #2 rst = 1'b1;
        #1;
        check("reset.outputs", outs, 0);
        check_counters("reset");
        repeat (2) @(posedge clk);
        @(negedge clk); #1 rst = 1'b0;
        check("reset_release.outputs", outs, 0);

        foreach (table_v[i]) apply($sformatf("table%0d", i), table_v[i]);

        // pmem_resp while idle must not move the FSM or touch the arrays.
        @(posedge clk); #1 pmem_resp = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("idle_pmem_resp%0d.outputs", i), outs, 0);
        end
        @(posedge clk); #1 pmem_resp = 1'b0;
        check_counters("idle_pmem_resp");

        // Reset two cycles into FILL.
        mem_read = 1'b1; tag_hit = 1'b0; line_valid = 1'b0; line_dirty = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk); #1;
        check("rst_fill.pmem_read_before", pmem_read, 1);
        pmem_resp = 1'b1;
        #1 rst = 1'b1;
        #1;
        check("rst_fill.outputs_async", outs, 0);
        exp_h = 0; exp_m = 0;
        check_counters("rst_fill.async");
        @(posedge clk); #1;
        check("rst_fill.outputs_held", outs, 0);
        @(negedge clk); #1;
        rst = 1'b0; pmem_resp = 1'b0; tag_hit = 1'b1; line_valid = 1'b1;
        #1;
        check("rst_fill.first_cycle_idle", outs, 0);
        @(negedge clk); #1;
        check("rst_fill.compare_hit_resp", mem_resp, 1);
        @(posedge clk); #1 mem_read = 1'b0;
        exp_h = 1;
        check_counters("rst_fill.after");

        // Randomized transactions.
        for (int n = 0; n < 40; n++) begin
            int sel = $urandom_range(0, 2);
            rv.rd    = (sel != 1);
            rv.wr    = (sel != 0);
            rv.hit   = $urandom_range(0, 1);
            rv.valid = $urandom_range(0, 1);
            rv.dirty = $urandom_range(0, 1);
            rv.wb    = $urandom_range(1, 5);
            rv.wf    = $urandom_range(1, 5);
            rv.drop  = -1;
            rv = model(rv);
            if (rv.exp_resp > 1 && $urandom_range(0, 3) == 0) begin
                rv.drop = $urandom_range(2, 2 + rv.exp_w + rv.wf);
                rv = model(rv);
            end
            apply($sformatf("rand%0d", n), rv);
        end

        // Saturation: 20 hits push the 4-bit counter to its ceiling.
        rv = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1, 1, -1, 1, 0, 0};
        for (int n = 0; n < 20; n++) apply($sformatf("sat%0d", n), rv);
        check("sat.s_hit_count_ceiling", s_hit_count, 15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
